// File: rtl/dma_debug_capture_if.sv
// Probe, control and readout bundle for dma_debug_capture.
// master is the driving side (probe source / readout consumer); slave is the capture unit.
interface dma_debug_capture_if #(
  parameter int unsigned NumCh   = 6,
  parameter int unsigned ChWidth = 36
);
  localparam int unsigned SelW = (NumCh > 1) ? $clog2(NumCh) : 1;

  logic [NumCh*ChWidth-1:0] probe;
  logic [SelW-1:0]          ch_sel;
  logic [ChWidth-1:0]       trig_mask;
  logic [ChWidth-1:0]       trig_value;
  logic                     arm;
  logic                     force_trig;
  logic                     abort;
  logic [2:0]               state;
  logic                     triggered;
  logic [ChWidth-1:0]       rd_data;
  logic                     rd_valid;
  logic                     rd_ready;
  logic                     rd_last;

  modport master (
    output probe, ch_sel, trig_mask, trig_value, arm, force_trig, abort, rd_ready,
    input  state, triggered, rd_data, rd_valid, rd_last
  );

  modport slave (
    input  probe, ch_sel, trig_mask, trig_value, arm, force_trig, abort, rd_ready,
    output state, triggered, rd_data, rd_valid, rd_last
  );
endinterface

// File: rtl/dma_debug_capture.sv
// Logic-analyser capture unit: masked-compare trigger, circular pre/post history buffer,
// and a valid/ready readout of the captured window, oldest sample first.
module dma_debug_capture #(
  parameter int unsigned NumCh     = 6,
  parameter int unsigned ChWidth   = 36,
  parameter int unsigned DepthLog2 = 10,
  parameter int unsigned Pretrig   = 256
) (
  input logic                 clk,
  input logic                 rst_n,
  dma_debug_capture_if.slave  cap_if
);

  localparam int unsigned Depth = 2 ** DepthLog2;
  localparam int unsigned SelW  = (NumCh > 1) ? $clog2(NumCh) : 1;

  typedef logic [DepthLog2-1:0] ptr_t;

  localparam ptr_t PreLast = ptr_t'(Pretrig - 1);
  localparam ptr_t PreOff  = ptr_t'(Pretrig);
  localparam ptr_t PostLen = ptr_t'(Depth - Pretrig - 1);
  localparam ptr_t LastIdx = ptr_t'(Depth - 1);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StPre   = 3'd1,
    StArmed = 3'd2,
    StPost  = 3'd3,
    StRead  = 3'd4
  } state_e;

  state_e             state_q, state_d;
  ptr_t               wptr_q, wptr_d;
  ptr_t               rptr_q, rptr_d;
  ptr_t               post_q, post_d;
  ptr_t               cnt_q, cnt_d;
  logic [SelW-1:0]    ch_sel_q, ch_sel_d;
  logic [ChWidth-1:0] mask_q, mask_d;
  logic [ChWidth-1:0] value_q, value_d;
  logic               trig_q, trig_d;
  logic               fetch_q, fetch_d;
  logic               rd_valid_q, rd_valid_d;
  logic               rd_last_q, rd_last_d;
  logic [ChWidth-1:0] rd_data_q, rd_data_d;

  logic [ChWidth-1:0] mem [Depth];
  logic [ChWidth-1:0] mem_rd_q;
  logic [ChWidth-1:0] sample;
  logic               we;
  logic               trig_hit;
  logic               handshake;

  // Out-of-range selects fall through to zero.
  always_comb begin
    sample = '0;
    for (int unsigned k = 0; k < NumCh; k++) begin
      if (ch_sel_q == SelW'(k)) sample = cap_if.probe[k*ChWidth +: ChWidth];
    end
  end

  assign trig_hit  = (((sample ^ value_q) & mask_q) == '0) || cap_if.force_trig;
  assign handshake = rd_valid_q && cap_if.rd_ready;

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    post_d     = post_q;
    cnt_d      = cnt_q;
    ch_sel_d   = ch_sel_q;
    mask_d     = mask_q;
    value_d    = value_q;
    trig_d     = trig_q;
    fetch_d    = fetch_q;
    rd_valid_d = rd_valid_q;
    rd_last_d  = rd_last_q;
    rd_data_d  = rd_data_q;
    we         = 1'b0;

    if (cap_if.abort) begin
      state_d    = StIdle;
      trig_d     = 1'b0;
      fetch_d    = 1'b0;
      rd_valid_d = 1'b0;
      rd_last_d  = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (cap_if.arm) begin
            ch_sel_d = cap_if.ch_sel;
            mask_d   = cap_if.trig_mask;
            value_d  = cap_if.trig_value;
            trig_d   = 1'b0;
            wptr_d   = '0;
            state_d  = (Pretrig == 0) ? StArmed : StPre;
          end
        end
        StPre: begin
          we     = 1'b1;
          wptr_d = wptr_q + ptr_t'(1);
          if (wptr_q == PreLast) state_d = StArmed;
        end
        StArmed: begin
          we     = 1'b1;
          wptr_d = wptr_q + ptr_t'(1);
          if (trig_hit) begin
            trig_d  = 1'b1;
            rptr_d  = wptr_q - PreOff;
            post_d  = PostLen;
            cnt_d   = '0;
            state_d = (PostLen == '0) ? StRead : StPost;
          end
        end
        StPost: begin
          we     = 1'b1;
          wptr_d = wptr_q + ptr_t'(1);
          post_d = post_q - ptr_t'(1);
          if (post_q == ptr_t'(1)) state_d = StRead;
        end
        StRead: begin
          // Two-stage fetch: address -> mem_rd_q -> rd_data_q.
          if (fetch_q) begin
            rd_valid_d = 1'b1;
            rd_data_d  = mem_rd_q;
            rd_last_d  = (cnt_q == LastIdx);
            fetch_d    = 1'b0;
          end else if (handshake) begin
            rd_valid_d = 1'b0;
            rd_last_d  = 1'b0;
            if (rd_last_q) state_d = StIdle;
            else           cnt_d   = cnt_q + ptr_t'(1);
          end else if (!rd_valid_q) begin
            fetch_d = 1'b1;
            rptr_d  = rptr_q + ptr_t'(1);
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      post_q     <= '0;
      cnt_q      <= '0;
      ch_sel_q   <= '0;
      mask_q     <= '0;
      value_q    <= '0;
      trig_q     <= 1'b0;
      fetch_q    <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      post_q     <= post_d;
      cnt_q      <= cnt_d;
      ch_sel_q   <= ch_sel_d;
      mask_q     <= mask_d;
      value_q    <= value_d;
      trig_q     <= trig_d;
      fetch_q    <= fetch_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Simple dual-port block RAM: no reset, registered read.
  always_ff @(posedge clk) begin
    if (we) mem[wptr_q] <= sample;
    mem_rd_q <= mem[rptr_q];
  end

  assign cap_if.state     = state_q;
  assign cap_if.triggered = trig_q;
  assign cap_if.rd_data   = rd_data_q;
  assign cap_if.rd_valid  = rd_valid_q;
  assign cap_if.rd_last   = rd_last_q;

endmodule
